// File: rtl/sel_scan_pkg.sv
// Shared types and constants for the select/latch scan controller.
// Imported by the round-robin picker and the controller top.
package sel_scan_pkg;

    localparam int N_CH = 3;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } sel_scan_state_t;

endpackage

// File: rtl/sel_scan_next.sv
// Combinational round-robin picker over the enabled channels.
// first_i picks the lowest enabled index, else the next one above sel_i.
module sel_scan_next
    import sel_scan_pkg::*;
(
    input  logic [N_CH-1:0] mask_i,
    input  logic [1:0]      sel_i,
    input  logic            first_i,
    output logic [1:0]      nxt_o
);

    logic [1:0] c1;
    logic [1:0] c2;

    // Pick the lowest set bit, or walk upward from sel_i with 2->0 wrap.
    always_comb begin
        c1    = (sel_i >= 2'd2) ? 2'd0 : sel_i + 2'd1;
        c2    = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        nxt_o = sel_i;
        if (first_i) begin
            if (mask_i[0])      nxt_o = 2'd0;
            else if (mask_i[1]) nxt_o = 2'd1;
            else if (mask_i[2]) nxt_o = 2'd2;
            else                nxt_o = 2'd0;
        end else begin
            if (mask_i[c1])      nxt_o = c1;
            else if (mask_i[c2]) nxt_o = c2;
            else                 nxt_o = sel_i;
        end
    end

endmodule

// File: rtl/sel_scan_ctrl.sv
// Scans enabled channels: holds le open for dwell+1 cycles, then
// closes it for one cycle while presenting a captured sample.
module sel_scan_ctrl
    import sel_scan_pkg::*;
#(
    parameter int DATA_W  = 2,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [2:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DATA_W-1:0]  idata0,
    input  logic [DATA_W-1:0]  idata1,
    input  logic [DATA_W-1:0]  idata2,
    output logic [1:0]         sel,
    output logic               le,
    output logic [DATA_W-1:0]  odata,
    output logic               ovalid,
    output logic               busy
);

    sel_scan_state_t state_q, state_d;

    logic [1:0]         sel_q, sel_d;
    logic [2:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  odata_q, odata_d;
    logic               stop_pend_q, stop_pend_d;

    logic              go;
    logic              done;
    logic              leave;
    logic [2:0]        pick_mask;
    logic [1:0]        pick_nxt;
    logic [DATA_W-1:0] sample;

    assign go    = start & ~stop & (|mask);
    assign done  = (cnt_q == dwell_q);
    assign leave = stop_pend_q | stop;

    // In IDLE the live mask feeds the picker; mask_q is not loaded yet.
    assign pick_mask = (state_q == IDLE) ? mask : mask_q;

    sel_scan_next u_next (
        .mask_i  (pick_mask),
        .sel_i   (sel_q),
        .first_i (state_q == IDLE),
        .nxt_o   (pick_nxt)
    );

    // Data mux for the channel currently being held open.
    always_comb begin
        sample = idata2;
        unique case (sel_q)
            2'd0:    sample = idata0;
            2'd1:    sample = idata1;
            default: sample = idata2;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = OPEN;
            OPEN:    if (done) state_d = CLOSE;
            CLOSE:   state_d = leave ? IDLE : OPEN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state plus the registered select and sample.
    always_comb begin
        le     = (state_q == OPEN);
        ovalid = (state_q == CLOSE);
        busy   = (state_q != IDLE);
        sel    = sel_q;
        odata  = odata_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            mask_q      <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            odata_q     <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            odata_q     <= odata_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Datapath next values: capture at start, count, sample, advance.
    always_comb begin
        sel_d       = sel_q;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        odata_d     = odata_q;
        stop_pend_d = stop_pend_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    mask_d      = mask;
                    dwell_d     = dwell;
                    sel_d       = pick_nxt;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                end
            end
            OPEN: begin
                if (stop) stop_pend_d = 1'b1;
                if (done) odata_d = sample;
                else      cnt_d = cnt_q + DWELL_W'(1);
            end
            CLOSE: begin
                cnt_d = '0;
                if (leave) stop_pend_d = 1'b0;
                else       sel_d = pick_nxt;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Scoreboard bench for sel_scan_ctrl: expected samples are queued as
// each scan is launched and popped whenever ovalid is seen.
module tb_sel_scan_ctrl;
    import sel_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] mask = '0;
    logic [3:0] dwell = '0;
    logic [1:0] idata0 = 2'b01;
    logic [1:0] idata1 = 2'b10;
    logic [1:0] idata2 = 2'b11;
    logic [1:0] sel;
    logic       le;
    logic [1:0] odata;
    logic       ovalid;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;
    logic [1:0] exp_q[$];

    sel_scan_ctrl #(.DATA_W(2), .DWELL_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .mask   (mask),
        .dwell  (dwell),
        .idata0 (idata0),
        .idata1 (idata1),
        .idata2 (idata2),
        .sel    (sel),
        .le     (le),
        .odata  (odata),
        .ovalid (ovalid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Per-cycle monitor: legal select, no le/ovalid overlap, sample pops.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n) begin
            n_total++;
            if (sel === SEL_ILLEGAL || $isunknown(sel))
                $display("FAIL sel_legal: sel=%b", sel);
            else n_pass++;
            n_total++;
            if ((le & ovalid) !== 1'b0)
                $display("FAIL le_ovalid_overlap: le=%b ovalid=%b", le, ovalid);
            else n_pass++;
            if (ovalid === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sample_unexpected: odata=%b, no sample expected", odata);
                end else begin
                    e = exp_q.pop_front();
                    if (odata !== e)
                        $display("FAIL sample_data: odata=%b expected %b", odata, e);
                    else n_pass++;
                end
            end
        end
    end

    task automatic kick(input logic [2:0] m, input logic [3:0] d);
        @(negedge clk);
        mask = m;
        dwell = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({sel, le, odata, ovalid, busy} !== 7'd0)
            $display("FAIL reset_state: sel=%0d le=%b odata=%b ovalid=%b busy=%b expected all 0",
                     sel, le, odata, ovalid, busy);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_open();
        exp_q.push_back(idata0);
        kick(3'b111, 4'd3);
        for (int c = 0; c < 7; c++) @(negedge clk);
        n_total++;
        if ({sel, le} !== {2'd1, 1'b1})
            $display("FAIL mid_open_pre: sel=%0d le=%b expected sel=1 le=1", sel, le);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({sel, le, odata, ovalid, busy} !== 7'd0)
            $display("FAIL async_reset: sel=%0d le=%b odata=%b ovalid=%b busy=%b expected all 0",
                     sel, le, odata, ovalid, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL mid_open_queue: %0d samples outstanding, expected 0", exp_q.size());
        else n_pass++;
        exp_q.push_back(idata0);
        kick(3'b001, 4'd1);
        @(negedge clk);
        n_total++;
        if ({sel, le, busy} !== {2'd0, 1'b1, 1'b1})
            $display("FAIL restart: sel=%0d le=%b busy=%b expected 0 1 1", sel, le, busy);
        else n_pass++;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        n_total++;
        if (ovalid !== 1'b1)
            $display("FAIL restart_ovalid: ovalid=%b expected 1", ovalid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL restart_idle: busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_full_scan();
        logic [1:0] es;
        exp_q.push_back(idata0);
        exp_q.push_back(idata1);
        exp_q.push_back(idata2);
        exp_q.push_back(idata0);
        exp_q.push_back(idata1);
        kick(3'b111, 4'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            es = 2'((c / 2) % 3);
            n_total++;
            if ({sel, le, ovalid} !== {es, c % 2 == 0, c % 2 == 1})
                $display("FAIL full_scan c=%0d: sel=%0d le=%b ovalid=%b expected %0d %b %b",
                         c, sel, le, ovalid, es, c % 2 == 0, c % 2 == 1);
            else n_pass++;
            if (c == 8) stop = 1'b1;
            if (c == 9) stop = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL full_scan_idle: busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_skipped_channel();
        logic [1:0] es;
        exp_q.push_back(idata0);
        exp_q.push_back(idata2);
        exp_q.push_back(idata0);
        kick(3'b101, 4'd2);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            es = ((c / 4) % 2 == 0) ? 2'd0 : 2'd2;
            n_total++;
            if ({sel, le, ovalid} !== {es, c % 4 < 3, c % 4 == 3})
                $display("FAIL skipped c=%0d: sel=%0d le=%b ovalid=%b expected %0d %b %b",
                         c, sel, le, ovalid, es, c % 4 < 3, c % 4 == 3);
            else n_pass++;
            if (c == 2) begin
                start = 1'b1;
                mask = 3'b111;
                dwell = 4'd0;
            end
            if (c == 3) start = 1'b0;
            if (c == 8) stop = 1'b1;
            if (c == 9) stop = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL skipped_idle: busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_stop_timing();
        logic [1:0] es;
        exp_q.push_back(idata0);
        exp_q.push_back(idata1);
        kick(3'b111, 4'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            es = (c < 5) ? 2'd0 : 2'd1;
            n_total++;
            if ({sel, le, ovalid} !== {es, c % 5 != 4, c % 5 == 4})
                $display("FAIL stop_timing c=%0d: sel=%0d le=%b ovalid=%b expected %0d %b %b",
                         c, sel, le, ovalid, es, c % 5 != 4, c % 5 == 4);
            else n_pass++;
            if (c == 6) stop = 1'b1;
            if (c == 7) stop = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if ({busy, le, ovalid, odata} !== {3'b000, idata1})
            $display("FAIL stop_idle: busy=%b le=%b ovalid=%b odata=%b expected 0 0 0 %b",
                     busy, le, ovalid, odata, idata1);
        else n_pass++;
    endtask

    task automatic test_degenerate();
        @(negedge clk);
        mask = 3'b000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if ({busy, le} !== 2'b00)
            $display("FAIL start_mask0: busy=%b le=%b expected 0 0", busy, le);
        else n_pass++;
        mask = 3'b111;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        n_total++;
        if ({busy, le} !== 2'b00)
            $display("FAIL start_with_stop: busy=%b le=%b expected 0 0", busy, le);
        else n_pass++;
        repeat (3) exp_q.push_back(idata1);
        kick(3'b010, 4'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_total++;
            if ({sel, le} !== {2'd1, c % 2 == 0})
                $display("FAIL single_ch c=%0d: sel=%0d le=%b expected 1 %b",
                         c, sel, le, c % 2 == 0);
            else n_pass++;
            if (c == 4) stop = 1'b1;
            if (c == 5) stop = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL single_ch_idle: busy=%b expected 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_open();
        test_full_scan();
        test_skipped_channel();
        test_stop_timing();
        test_degenerate();
        repeat (2) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL samples_outstanding: %0d left, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
